// File: rtl/fetch_seq_ctrl_pkg.sv
// rtl/fetch_seq_ctrl_pkg.sv - shared frontend types and widths for the fetch sequencer
package fetch_seq_ctrl_pkg;

    localparam int PC_W    = 48;
    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_KILL = 3'd4
    } fetch_state_t;

    // Start of the next 16-byte fetch block; wraps naturally at 2^48.
    function automatic logic [PC_W-1:0] next_block_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:4] + (PC_W-4)'(1), 4'b0000};
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - single-outstanding instruction fetch sequencer with redirect flush
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] BOOT_ADDR = 48'h0000_8000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               icache_req_valid,
    input  logic               icache_req_ready,
    output logic [ADDR_W-1:0]  icache_req_addr,
    input  logic               icache_resp_done,
    input  logic [BLOCK_W-1:0] icache_resp_data,
    output logic               fetch_out_valid,
    input  logic               fetch_out_ready,
    output logic [BLOCK_W-1:0] fetch_out_data,
    output logic [ADDR_W-1:0]  fetch_out_pc,
    output logic               busy,
    output logic [31:0]        fetch_count,
    output logic [15:0]        kill_count
);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [PC_W-1:0]    pc;
    logic [BLOCK_W-1:0] data_q;

    logic load_target;
    logic advance_pc;
    logic capture;
    logic count_fetch;
    logic count_kill;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect always wins over a same-cycle handshake; a response already in
    // flight at redirect time must be drained through KILL before re-requesting.
    always_comb begin
        state_d     = state_q;
        load_target = 1'b0;
        advance_pc  = 1'b0;
        capture     = 1'b0;
        count_fetch = 1'b0;
        count_kill  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_target = redirect_valid;
                state_d     = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    load_target = 1'b1;
                    state_d     = icache_req_ready ? ST_KILL : ST_REQ;
                end else if (icache_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    load_target = 1'b1;
                    count_kill  = icache_resp_done;
                    state_d     = icache_resp_done ? ST_REQ : ST_KILL;
                end else if (icache_resp_done) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    load_target = 1'b1;
                    state_d     = ST_REQ;
                end else if (fetch_out_ready) begin
                    advance_pc  = 1'b1;
                    count_fetch = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_KILL: begin
                load_target = redirect_valid;
                if (icache_resp_done) begin
                    count_kill = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        icache_req_valid = (state_q == ST_REQ);
        fetch_out_valid  = (state_q == ST_HOLD);
        busy             = (state_q != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= BOOT_ADDR;
            data_q      <= '0;
            fetch_count <= '0;
            kill_count  <= '0;
        end else begin
            if (load_target) begin
                pc <= redirect_target;
            end else if (advance_pc) begin
                pc <= next_block_pc(pc);
            end
            if (capture) begin
                data_q <= icache_resp_data;
            end
            if (count_fetch) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (count_kill && (kill_count != 16'hFFFF)) begin
                kill_count <= kill_count + 16'd1;
            end
        end
    end

    assign icache_req_addr = {16'b0, pc[PC_W-1:4], 4'b0000};
    assign fetch_out_pc    = {16'b0, pc};
    assign fetch_out_data  = data_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - directed and randomized checks of fetch_seq_ctrl against a transaction model
module tb_fetch_seq_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         redirect_valid;
    logic [47:0]  redirect_target;
    logic         icache_req_valid;
    logic         icache_req_ready;
    logic [63:0]  icache_req_addr;
    logic         icache_resp_done;
    logic [127:0] icache_resp_data;
    logic         fetch_out_valid;
    logic         fetch_out_ready;
    logic [127:0] fetch_out_data;
    logic [63:0]  fetch_out_pc;
    logic         busy;
    logic [31:0]  fetch_count;
    logic [15:0]  kill_count;

    fetch_seq_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_req_addr  (icache_req_addr),
        .icache_resp_done (icache_resp_done),
        .icache_resp_data (icache_resp_data),
        .fetch_out_valid  (fetch_out_valid),
        .fetch_out_ready  (fetch_out_ready),
        .fetch_out_data   (fetch_out_data),
        .fetch_out_pc     (fetch_out_pc),
        .busy             (busy),
        .fetch_count      (fetch_count),
        .kill_count       (kill_count)
    );

    always #5 clock = ~clock;

    // Transaction-level model: started / request outstanding / outstanding response is stale / block held.
    bit           m_started;
    bit           m_outstanding;
    bit           m_stale;
    bit           m_have_block;
    logic [47:0]  m_pc;
    logic [127:0] m_block;
    logic [31:0]  m_fetches;
    logic [15:0]  m_kills;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_started     = 0;
        m_outstanding = 0;
        m_stale       = 0;
        m_have_block  = 0;
        m_pc          = 48'h0000_8000_0000;
        m_block       = '0;
        m_fetches     = 0;
        m_kills       = 0;
    endtask

    task automatic count_kill();
        if (m_kills != 16'hFFFF) m_kills = m_kills + 1;
    endtask

    task automatic model_step();
        if (!m_started) begin
            m_started = 1;
            if (redirect_valid) m_pc = redirect_target;
        end else if (m_have_block) begin
            if (redirect_valid) begin
                m_have_block = 0;
                m_pc = redirect_target;
            end else if (fetch_out_ready) begin
                m_have_block = 0;
                m_fetches = m_fetches + 1;
                m_pc = (m_pc & ~48'hF) + 48'd16;
            end
        end else if (m_outstanding) begin
            if (redirect_valid) m_pc = redirect_target;
            if (icache_resp_done) begin
                m_outstanding = 0;
                if (m_stale || redirect_valid) count_kill();
                else begin
                    m_block = icache_resp_data;
                    m_have_block = 1;
                end
                m_stale = 0;
            end else if (redirect_valid) begin
                m_stale = 1;
            end
        end else begin
            if (redirect_valid) m_pc = redirect_target;
            if (icache_req_ready) begin
                m_outstanding = 1;
                m_stale = redirect_valid;
            end
        end
    endtask

    task automatic check_all();
        chk("req_valid", icache_req_valid, m_started && !m_outstanding && !m_have_block);
        chk("req_addr", icache_req_addr, {16'b0, m_pc[47:4], 4'b0});
        chk("out_valid", fetch_out_valid, m_have_block);
        chk("out_data", fetch_out_data, m_block);
        chk("out_pc", fetch_out_pc, {16'b0, m_pc});
        chk("busy", busy, m_started);
        chk("fetch_count", fetch_count, m_fetches);
        chk("kill_count", kill_count, m_kills);
    endtask

    task automatic step(input logic rv, input logic [47:0] rt, input logic rr,
                        input logic dn, input logic [127:0] dd, input logic orr);
        redirect_valid   = rv;
        redirect_target  = rt;
        icache_req_ready = rr;
        icache_resp_done = dn;
        icache_resp_data = dd;
        fetch_out_ready  = orr;
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [127:0] rnd_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] held_data;
    logic [63:0]  held_pc;
    logic [31:0]  r0;
    logic [31:0]  r1;

    initial begin
        reset = 1'b1;
        redirect_valid = 0; redirect_target = '0; icache_req_ready = 0;
        icache_resp_done = 0; icache_resp_data = '0; fetch_out_ready = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clock);
        reset = 1'b0;

        // Two back-to-back sequential fetches from the boot address.
        step(0, 0, 1, 0, 0, 1);
        chk("boot_addr", icache_req_addr, 64'h8000_0000);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, rnd_block(), 1);
        chk("hold_valid", fetch_out_valid, 1'b1);
        step(0, 0, 1, 0, 0, 1);
        chk("second_addr", icache_req_addr, 64'h8000_0010);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, rnd_block(), 1);
        step(0, 0, 1, 0, 0, 1);
        chk("two_fetches", fetch_count, 32'd2);

        // Redirect while waiting, then the stale response arrives.
        step(0, 0, 1, 0, 0, 1);
        step(1, 48'h1234, 0, 0, 0, 1);
        step(0, 0, 0, 1, rnd_block(), 1);
        chk("kill_one", kill_count, 16'd1);
        chk("kill_addr", icache_req_addr, 64'h1230);
        chk("kill_pc", fetch_out_pc, 64'h1234);

        // Back-pressure on the output holds everything stable.
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, rnd_block(), 0);
        held_data = fetch_out_data;
        held_pc   = fetch_out_pc;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, rnd_block(), 0);
            chk("stall_valid", fetch_out_valid, 1'b1);
            chk("stall_data", fetch_out_data, held_data);
            chk("stall_pc", fetch_out_pc, held_pc);
            chk("stall_noreq", icache_req_valid, 1'b0);
        end
        step(0, 0, 0, 0, 0, 1);

        // Redirect on the request handshake, newer redirect while killing.
        step(1, 48'h5000, 1, 0, 0, 0);
        step(1, 48'h2000, 0, 0, 0, 0);
        step(0, 0, 0, 1, rnd_block(), 0);
        chk("kill_newest", icache_req_addr, 64'h2000);

        // PC wrap at the top of the 48-bit space.
        step(1, 48'hFFFF_FFFF_FFF0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, rnd_block(), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("wrap_addr", icache_req_addr, 64'h0);

        // Reset in WAIT, late response after release is ignored.
        step(0, 0, 1, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0, 1, rnd_block(), 0);
        chk("rst_addr", icache_req_addr, 64'h8000_0000);
        chk("rst_kills", kill_count, 16'd0);
        chk("rst_reqv", icache_req_valid, 1'b1);

        // Randomized traffic, including redirects in every phase and stray responses.
        for (int i = 0; i < 3000; i++) begin
            r0 = $urandom;
            r1 = $urandom;
            step(($urandom_range(0, 9) == 0), {r1[15:0], r0},
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
                 rnd_block(), ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
